// File: rtl/data_mem_adapter_pkg.sv
// Shared types for the data-memory adapter: access size encoding and the
// alignment rule used when a core request is first seen.
package data_mem_adapter_pkg;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2
  } DataAccess;

  // Halves need an even address, words a multiple of four; bytes never fault.
  function automatic logic is_misaligned(DataAccess acc, logic [1:0] lo);
    case (acc)
      ACC_HALF: return lo[0];
      ACC_WORD: return |lo;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_adapter_aligner.sv
// Combinational lane logic: store replication, byte enables and load
// shift/extension for a 32-bit memory word.
module data_lane_aligner
  import data_mem_adapter_pkg::*;
(
  input  DataAccess   access,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [31:0] wr_lanes,
  output logic [3:0]  byte_en,
  output logic [31:0] rd_data
);

  logic [31:0] rd_shift;

  always_comb begin
    rd_shift = rd_word >> {addr_lo, 3'b000};
    wr_lanes = wr_data;
    byte_en  = 4'b1111;
    rd_data  = rd_shift;
    case (access)
      ACC_BYTE: begin
        wr_lanes = {4{wr_data[7:0]}};
        byte_en  = 4'b0001 << addr_lo;
        rd_data  = is_unsigned ? {24'd0, rd_shift[7:0]}
                               : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      ACC_HALF: begin
        wr_lanes = {2{wr_data[15:0]}};
        byte_en  = 4'b0011 << addr_lo;
        rd_data  = is_unsigned ? {16'd0, rd_shift[15:0]}
                               : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_adapter.sv
// Core-to-memory load/store adapter: IDLE -> ACCESS -> DONE handshake with
// alignment checking, lane steering and an ack timeout.
module data_mem_adapter
  import data_mem_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  DataAccess             i_access,
  input  logic                  i_unsigned,
  input  logic                  i_wrEnable,
  input  logic                  i_rdEnable,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  output logic [DATA_WIDTH-1:0] o_rdData,
  output logic                  o_busy,
  output logic                  o_misaligned,
  output logic                  o_timeout,
  output logic [ADDR_WIDTH-1:0] o_memAddr,
  output logic [3:0]            o_memByteEn,
  output logic [DATA_WIDTH-1:0] o_memWrData,
  output logic                  o_memWrEnable,
  output logic                  o_memReq,
  input  logic                  i_memAck,
  input  logic [DATA_WIDTH-1:0] i_memRdData
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  DataAccess             access_q, access_d;
  logic                  unsigned_q, unsigned_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic                  misaligned_q, misaligned_d;
  logic                  timeout_q, timeout_d;

  logic        req, misalign;
  DataAccess   al_access;
  logic [1:0]  al_lo;
  logic        al_uns;
  logic [31:0] al_wr_lanes, al_rd_data;
  logic [3:0]  al_be;

  assign req      = i_wrEnable | i_rdEnable;
  assign misalign = is_misaligned(i_access, i_addr[1:0]);

  // Store side is needed while accepting in IDLE, load side only in ACCESS.
  assign al_access = (state_q == S_IDLE) ? i_access     : access_q;
  assign al_lo     = (state_q == S_IDLE) ? i_addr[1:0]  : addr_lo_q;
  assign al_uns    = (state_q == S_IDLE) ? i_unsigned   : unsigned_q;

  data_lane_aligner u_aligner (
    .access      (al_access),
    .addr_lo     (al_lo),
    .is_unsigned (al_uns),
    .wr_data     (i_wrData),
    .rd_word     (i_memRdData),
    .wr_lanes    (al_wr_lanes),
    .byte_en     (al_be),
    .rd_data     (al_rd_data)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_lo_d     = addr_lo_q;
    access_d      = access_q;
    unsigned_d    = unsigned_q;
    rd_data_d     = rd_data_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_be_d      = mem_be_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    misaligned_d  = 1'b0;
    timeout_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && misalign) begin
          misaligned_d = 1'b1;
        end else if (req) begin
          state_d       = S_ACCESS;
          cnt_d         = '0;
          addr_lo_d     = i_addr[1:0];
          access_d      = i_access;
          unsigned_d    = i_unsigned;
          mem_addr_d    = {i_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wr_data_d = al_wr_lanes;
          mem_be_d      = al_be;
          mem_we_d      = i_wrEnable;
          mem_req_d     = 1'b1;
        end
      end
      S_ACCESS: begin
        // Ack is tested first so it wins over an expiring counter.
        if (i_memAck) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (!mem_we_q) rd_data_d = al_rd_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          rd_data_d = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_data_q    <= '0;
      mem_be_q     <= 4'b0000;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_data_q    <= rd_data_d;
      mem_be_q     <= mem_be_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
    addr_lo_q     <= addr_lo_d;
    access_q      <= access_d;
    unsigned_q    <= unsigned_d;
    mem_addr_q    <= mem_addr_d;
    mem_wr_data_q <= mem_wr_data_d;
  end

  assign o_busy        = (state_q == S_ACCESS) || ((state_q == S_IDLE) && req && !misalign);
  assign o_rdData      = rd_data_q;
  assign o_misaligned  = misaligned_q;
  assign o_timeout     = timeout_q;
  assign o_memAddr     = mem_addr_q;
  assign o_memByteEn   = mem_be_q;
  assign o_memWrData   = mem_wr_data_q;
  assign o_memWrEnable = mem_we_q;
  assign o_memReq      = mem_req_q;

endmodule

// File: tb/tb_data_mem_adapter.sv
// Scoreboard bench for data_mem_adapter: directed cases plus random traffic
// predicted by a byte-level reference model.
module tb_data_mem_adapter;
  import data_mem_adapter_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_addr;
  DataAccess   i_access;
  logic        i_unsigned, i_wrEnable, i_rdEnable;
  logic [31:0] i_wrData;
  logic [31:0] o_rdData;
  logic        o_busy, o_misaligned, o_timeout;
  logic [31:0] o_memAddr;
  logic [3:0]  o_memByteEn;
  logic [31:0] o_memWrData;
  logic        o_memWrEnable, o_memReq;
  logic        i_memAck;
  logic [31:0] i_memRdData;

  always #5 clk = ~clk;

  data_mem_adapter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_addr(i_addr), .i_access(i_access),
    .i_unsigned(i_unsigned), .i_wrEnable(i_wrEnable), .i_rdEnable(i_rdEnable),
    .i_wrData(i_wrData), .o_rdData(o_rdData), .o_busy(o_busy),
    .o_misaligned(o_misaligned), .o_timeout(o_timeout), .o_memAddr(o_memAddr),
    .o_memByteEn(o_memByteEn), .o_memWrData(o_memWrData),
    .o_memWrEnable(o_memWrEnable), .o_memReq(o_memReq),
    .i_memAck(i_memAck), .i_memRdData(i_memRdData)
  );

  typedef struct {
    bit          mis;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          we;
    logic [31:0] rdata;
    bit          to;
    int          busy;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_rd = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: a size-n access is legal iff addr is a multiple of n; loads
  // gather n bytes from the word and sign-extend arithmetically.
  task automatic predict(input DataAccess acc, input logic [31:0] addr, input bit uns,
                         input bit wr, input logic [31:0] wd, input logic [31:0] mw,
                         input int delay, output exp_t e);
    int lo, n;
    longint v;
    lo = int'(addr % 32'd4);
    n  = (acc == ACC_BYTE) ? 1 : (acc == ACC_HALF) ? 2 : 4;
    e.mis   = (lo % n) != 0;
    e.addr  = addr - 32'(lo);
    e.be    = 4'(((1 << n) - 1) << lo);
    e.wdata = (n == 1) ? (wd & 32'hFF) * 32'h01010101 :
              (n == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    e.we    = wr;
    e.to    = !e.mis && (delay >= TMO);
    e.busy  = e.mis ? 0 : (e.to ? TMO + 1 : delay + 2);
    if (e.mis || (wr && !e.to)) e.rdata = model_rd;
    else if (e.to) e.rdata = 32'd0;
    else begin
      v = 0;
      for (int k = 0; k < n; k++)
        v = v | (longint'((mw >> (8 * (lo + k))) & 32'hFF) << (8 * k));
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
        v = v - (longint'(1) << (8 * n));
      e.rdata = v[31:0];
    end
    model_rd = e.rdata;
  endtask

  // delay = number of ACCESS cycles before the one carrying the ack.
  task automatic txn(input DataAccess acc, input logic [31:0] addr, input bit uns,
                     input bit wr, input bit rd, input logic [31:0] wd,
                     input logic [31:0] mw, input int delay);
    exp_t e;
    int   n_acc;
    predict(acc, addr, uns, wr, wd, mw, delay, e);
    exp_q.push_back(e);
    i_addr = addr; i_access = acc; i_unsigned = uns;
    i_wrEnable = wr; i_rdEnable = rd; i_wrData = wd;
    @(posedge clk); #1;
    i_wrEnable = 1'b0; i_rdEnable = 1'b0;
    i_addr = $urandom; i_wrData = $urandom; i_unsigned = 1'($urandom_range(0, 1));
    i_access = DataAccess'($urandom_range(0, 2));
    if (!e.mis) begin
      n_acc = (delay < TMO) ? delay + 1 : TMO;
      for (int i = 0; i < n_acc; i++) begin
        i_memAck    = (i == delay);
        i_memRdData = (i == delay) ? mw : $urandom;
        @(posedge clk); #1;
      end
    end
    // Stray acks in DONE / IDLE must be ignored.
    repeat (2) begin
      i_memAck = 1'($urandom_range(0, 1)); i_memRdData = $urandom;
      @(posedge clk); #1;
    end
    i_memAck = 1'b0;
  endtask

  int busy_cnt = 0;
  bit prev_busy = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!i_reset) begin
      exp_q.delete();
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (o_memReq) begin
        if (exp_q.size() == 0 || exp_q[0].mis) begin
          checks++; failures++;
          $display("FAIL unexpected_memreq: got memReq=1 addr=%h expected no request", o_memAddr);
        end else begin
          chk("mem_addr", o_memAddr, exp_q[0].addr);
          chk("mem_byte_en", 32'(o_memByteEn), 32'(exp_q[0].be));
          chk("mem_wr_enable", 32'(o_memWrEnable), 32'(exp_q[0].we));
          if (exp_q[0].we) chk("mem_wr_data", o_memWrData, exp_q[0].wdata);
        end
      end
      if (o_busy) busy_cnt++;
      if (o_misaligned) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_misaligned: got pulse expected none");
        end else begin
          e = exp_q.pop_front();
          chk("misaligned_kind", 32'(e.mis), 32'd1);
          chk("busy_on_misaligned", 32'(o_busy), 32'd0);
          chk("busy_cycles_mis", 32'(busy_cnt), 32'(e.busy));
          chk("rd_after_misaligned", o_rdData, e.rdata);
        end
        busy_cnt = 0;
      end else if (prev_busy && !o_busy) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_done: got completion expected none");
        end else begin
          e = exp_q.pop_front();
          chk("done_kind", 32'(e.mis), 32'd0);
          chk("rd_data", o_rdData, e.rdata);
          chk("timeout_pulse", 32'(o_timeout), 32'(e.to));
          chk("memreq_in_done", 32'(o_memReq), 32'd0);
          chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
        end
        busy_cnt = 0;
      end else if (o_timeout) begin
        checks++; failures++;
        $display("FAIL spurious_timeout: got pulse expected none");
      end
      prev_busy = o_busy;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    i_reset = 1'b0; i_addr = '0; i_access = ACC_WORD; i_unsigned = 1'b0;
    i_wrEnable = 1'b0; i_rdEnable = 1'b0; i_wrData = '0;
    i_memAck = 1'b0; i_memRdData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_data", o_rdData, 32'd0);
    chk("rst_mem_req", 32'(o_memReq), 32'd0);
    chk("rst_mem_we", 32'(o_memWrEnable), 32'd0);
    chk("rst_mem_be", 32'(o_memByteEn), 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); #1;

    txn(ACC_BYTE, 32'h103, 1'b0, 1'b0, 1'b1, 32'h0, 32'h80AA55CC, 0);
    txn(ACC_HALF, 32'h202, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, 1);
    txn(ACC_WORD, 32'h301, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 0);
    txn(ACC_WORD, 32'h400, 1'b0, 1'b0, 1'b1, 32'h0, 32'h11111111, 10);
    txn(ACC_HALF, 32'h002, 1'b1, 1'b0, 1'b1, 32'h0, 32'hBEEF0000, 2);
    txn(ACC_BYTE, 32'h005, 1'b0, 1'b1, 1'b1, 32'h5A5A5AA5, 32'h0, 0);
    txn(ACC_WORD, 32'h010, 1'b0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, TMO - 1);
    txn(ACC_HALF, 32'h007, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 0);

    // Reset in the second ACCESS cycle, then a late ack.
    predict(ACC_WORD, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 100, e);
    exp_q.push_back(e);
    i_addr = 32'h500; i_access = ACC_WORD; i_rdEnable = 1'b1;
    @(posedge clk); #1;
    i_rdEnable = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b1; i_memAck = 1'b1; i_memRdData = 32'h12345678;
    @(negedge clk);
    chk("reset_drops_memreq", 32'(o_memReq), 32'd0);
    chk("reset_clears_rd", o_rdData, 32'd0);
    chk("reset_to_idle_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    i_memAck = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored_rd", o_rdData, 32'd0);
    chk("late_ack_no_req", 32'(o_memReq), 32'd0);
    model_rd = 32'd0;
    @(posedge clk); #1;

    for (int t = 0; t < 200; t++) begin
      DataAccess a;
      bit w, r;
      a = DataAccess'($urandom_range(0, 2));
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (!w && !r) r = 1'b1;
      txn(a, $urandom, 1'($urandom_range(0, 1)), w, r, $urandom, $urandom,
          int'($urandom_range(0, 5)));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_adapter.md
DATA_MEM_ADAPTER -- requirements
Module: data_mem_adapter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: core and memory data width; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for i_memAck.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 i_clock  in  1  clock; all state changes on the rising edge.
REQ-006 i_reset  in  1  synchronous reset, active-low.
REQ-007 i_addr  in  ADDR_WIDTH  core byte address.
REQ-008 i_access  in  DataAccess  access size: byte, half or word.
REQ-009 i_unsigned  in  1  zero-extend read data; otherwise sign-extend.
REQ-010 i_wrEnable / i_rdEnable  in  1 each  core write / read request.
REQ-011 i_wrData  in  DATA_WIDTH  core store data, right-aligned.
REQ-012 o_rdData  out  DATA_WIDTH  extended load data.
REQ-013 o_busy  out  1  core stall; the core holds its PC while high.
REQ-014 o_misaligned / o_timeout  out  1 each  one-cycle error pulses.
REQ-015 o_memAddr  out  ADDR_WIDTH  word-aligned address, bits [1:0] always 0.
REQ-016 o_memByteEn  out  4  byte-lane enables.
REQ-017 o_memWrData / o_memWrEnable / o_memReq  out  DATA_WIDTH / 1 / 1  memory write data, write strobe, request.
REQ-018 i_memAck / i_memRdData  in  1 / DATA_WIDTH  memory completion and read data.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE.
REQ-020 IDLE: an aligned request registers address, access, unsigned, write flag and lane-shifted write data, then moves to ACCESS. o_busy is driven combinationally high in that same cycle.
REQ-021 When i_wrEnable and i_rdEnable are both high, the access is a write.
REQ-022 Misaligned access (half with addr[0]=1; word with addr[1:0]≠0): stay in IDLE, o_misaligned=1 for one cycle, o_busy=0, no o_memReq.
REQ-023 ACCESS: o_memReq=1. o_memAddr, o_memByteEn, o_memWrData and o_memWrEnable stay stable until i_memAck. o_busy=1.
REQ-024 Byte lanes:
  - byte: be=0001<<addr[1:0], data replicated 4×.
  - half: be=0011<<addr[1:0], data replicated 2×.
  - word: be=1111.
REQ-025 On i_memAck in ACCESS: register the read lanes shifted right by addr[1:0]×8, extended per i_unsigned, into o_rdData; go to DONE. For writes, o_rdData is unchanged.
REQ-026 The timeout counter clears on entering ACCESS. If it reaches TIMEOUT without i_memAck: o_timeout pulses, o_rdData=0, go to DONE. If ack and the limit occur in the same cycle, ack wins.
REQ-027 DONE: o_busy=0, o_memReq=0, o_rdData valid; next state is always IDLE. This gives a minimum latency of 3 cycles per access (ack in the first ACCESS cycle).
REQ-028 i_memAck is ignored in IDLE and DONE.
REQ-029 Requests are sampled only in IDLE. A request held through DONE does not re-trigger.

Reset
REQ-030 When i_reset is low at a clock edge:
  - state=IDLE, counter=0.
  - o_rdData=0, o_memReq=0, o_memWrEnable=0, o_memByteEn=0.
  - o_misaligned=0, o_timeout=0.
REQ-031 Reset during ACCESS drops o_memReq on that edge. A late i_memAck after reset has no effect.

Structure
REQ-032 DataAccess comes from the shared Types package.
REQ-033 The FSM state typedef is local to the module.
REQ-034 One combinational sub-module, data_lane_aligner, performs write lane replication, byte-enable generation, and read shift/extension.

Verification
REQ-035 Byte load, addr=0x103, mem word 0x80AA55CC, signed, ack on 1st ACCESS cycle -> o_rdData=0xFFFFFF80 in DONE, cycle 2.
REQ-036 Half store, addr=0x202, wrData=0x1234 -> o_memAddr=0x200, be=1100, o_memWrData=0x12341234, o_memWrEnable=1 until ack.
REQ-037 Word load, addr=0x301 -> o_misaligned=1 for one cycle, o_memReq never asserted, o_busy=0.
REQ-038 Word load, TIMEOUT=4, no ack -> o_timeout pulse after 4 ACCESS cycles, o_rdData=0, then IDLE.
REQ-039 Reset low in the 2nd ACCESS cycle, ack arrives one cycle later -> o_memReq=0, state IDLE, o_rdData=0.
REQ-040 Unsigned half load, addr=0x2, mem word 0xBEEF0000, ack delayed 3 cycles -> o_busy high 4 cycles, o_rdData=0x0000BEEF.
